// File: rtl/c_reg_fd_v5_0_if.sv
// Data/control bundle for the c_reg_fd_v5_0 output register.
// The master drives D and the synchronous controls and reads back Q.
// The slave is the register itself.
interface c_reg_fd_v5_0_if #(
  parameter int C_WIDTH = 8
);
  logic [C_WIDTH-1:0] D;
  logic               CE;
  logic               SCLR;
  logic               SSET;
  logic               SINIT;
  logic [C_WIDTH-1:0] Q;

  modport master (output D, CE, SCLR, SSET, SINIT, input Q);
  modport slave  (input D, CE, SCLR, SSET, SINIT, output Q);
endinterface

// File: rtl/c_reg_fd_v5_0.sv
// c_reg_fd_v5_0: C_WIDTH-bit D register with clock enable and an asynchronous
// active-low clear.
// It also has optional synchronous SINIT, SCLR and SSET controls.
//
// Optional build macro C_REG_FD_XPROP_EN selects X-pessimistic simulation
// behaviour:
// - An X on CE, an X on ACLR_N, or a 0->X clock edge turns into X every Q bit
//   whose candidate value differs from its current value.
// Without the macro, X on any control is treated as inactive.
// Synthesis results are the same with or without the macro.
//
// Init strings are binary text, MSB first. A missing MSB character reads as
// '0', extra MSB characters are dropped, and any other character loads X.
module c_reg_fd_v5_0 #(
  parameter int C_WIDTH         = 8,
  parameter     C_AINIT_VAL     = "",
  parameter     C_SINIT_VAL     = "",
  parameter int C_HAS_CE        = 0,
  parameter int C_HAS_SCLR      = 0,
  parameter int C_HAS_SSET      = 0,
  parameter int C_HAS_SINIT     = 0,
  parameter int C_SYNC_ENABLE   = 0,
  parameter int C_SYNC_PRIORITY = 1,
  parameter int C_ENABLE_RLOCS  = 1
) (
  input  logic                 CLK,
  input  logic                 ACLR_N,
  c_reg_fd_v5_0_if.slave       bus
);

  // The string literal is read as packed bytes: the last character is in
  // bits [7:0].
  // Zero-extension pads the MSB side with NUL bytes, and a NUL byte marks the
  // end of the string.
  function automatic logic [C_WIDTH-1:0] init_decode(input logic [8*C_WIDTH+7:0] s);
    logic [C_WIDTH-1:0] v;
    logic               done;
    logic [7:0]         c;
    v    = '0;
    done = 1'b0;
    for (int k = 0; k < C_WIDTH; k++) begin
      c = s[8*k +: 8];
      if (c == 8'h00) done = 1'b1;
      if (!done) begin
        if (c == "1")      v[k] = 1'b1;
        else if (c == "0") v[k] = 1'b0;
        else               v[k] = 1'bx;
      end
    end
    return v;
  endfunction

  localparam logic [C_WIDTH-1:0] AINIT = init_decode((8*C_WIDTH+8)'(C_AINIT_VAL));
  localparam logic [C_WIDTH-1:0] SINIT = init_decode((8*C_WIDTH+8)'(C_SINIT_VAL));
  localparam logic [C_WIDTH-1:0] ONES  = '1;

  // Next-state priority: SINIT, then SCLR/SSET (with the configured tie-break),
  // then CE loading D, otherwise hold.
  // With C_SYNC_ENABLE=1 the sync controls are gated by CE.
  function automatic logic [C_WIDTH-1:0] next_value(
    input logic               ce,
    input logic               sclr,
    input logic               sset,
    input logic               sinit,
    input logic [C_WIDTH-1:0] d,
    input logic [C_WIDTH-1:0] q
  );
    logic sync_ok;
    sync_ok = (C_SYNC_ENABLE == 0) || (ce == 1'b1);
    if (sync_ok && sinit == 1'b1)                  return SINIT;
    else if (sync_ok && sclr == 1'b1 && sset == 1'b1)
      return (C_SYNC_PRIORITY == 1) ? '0 : ONES;
    else if (sync_ok && sclr == 1'b1)              return '0;
    else if (sync_ok && sset == 1'b1)              return ONES;
    else if (ce == 1'b1)                           return d;
    else                                           return q;
  endfunction

  logic               ce_e;
  logic               sclr_e;
  logic               sset_e;
  logic               sinit_e;
  logic [C_WIDTH-1:0] q_r;
  logic [C_WIDTH-1:0] next_q;
  logic [C_WIDTH-1:0] next_ce1;

  // Disabled controls are forced to their inactive level, so whatever is
  // driven on them is ignored.
  always_comb begin
    ce_e    = (C_HAS_CE    != 0) ? bus.CE    : 1'b1;
    sclr_e  = (C_HAS_SCLR  != 0) ? bus.SCLR  : 1'b0;
    sset_e  = (C_HAS_SSET  != 0) ? bus.SSET  : 1'b0;
    sinit_e = (C_HAS_SINIT != 0) ? bus.SINIT : 1'b0;
  end

  // next_q is the candidate value for the next edge.
  // next_ce1 is the value Q would take if CE were 1.
  always_comb begin
    next_q   = next_value(ce_e, sclr_e, sset_e, sinit_e, bus.D, q_r);
    next_ce1 = next_value(1'b1, sclr_e, sset_e, sinit_e, bus.D, q_r);
  end

`ifdef C_REG_FD_XPROP_EN
  function automatic logic [C_WIDTH-1:0] xmerge(
    input logic [C_WIDTH-1:0] a,
    input logic [C_WIDTH-1:0] b
  );
    logic [C_WIDTH-1:0] r;
    for (int i = 0; i < C_WIDTH; i++) r[i] = (a[i] === b[i]) ? a[i] : 1'bx;
    return r;
  endfunction

  // X-pessimistic register: an unknown CE, ACLR_N or clock level blurs only
  // the bits that could change.
  always_ff @(posedge CLK or negedge ACLR_N) begin
    if (!ACLR_N)                  q_r <= AINIT;
    else if ($isunknown(ACLR_N))  q_r <= xmerge(q_r, AINIT);
    else if (CLK !== 1'b1)        q_r <= xmerge(q_r, next_q);
    else if ($isunknown(ce_e))    q_r <= xmerge(q_r, next_ce1);
    else                          q_r <= next_q;
  end
`else
  // Plain register: the async clear loads AINIT; otherwise the next-state
  // value is captured on the rising edge.
  always_ff @(posedge CLK or negedge ACLR_N) begin
    if (!ACLR_N) q_r <= AINIT;
    else         q_r <= next_q;
  end
`endif

  assign bus.Q = q_r;

  // Inputs of disabled ports and the placement hint have no function here.
  logic unused_ok;
  assign unused_ok = &{1'b0, bus.CE, bus.SCLR, bus.SSET, bus.SINIT,
                       (C_ENABLE_RLOCS != 0), next_ce1[0]};

endmodule

// File: tb/tb_c_reg_fd_v5_0.sv
// Directed bench for c_reg_fd_v5_0, covering three configurations:
//   u0: all ports, SCLR wins, sync controls override CE
//   u1: all ports, SSET wins, sync controls gated by CE
//   u2: no optional ports, short AINIT string "101" (reads as 8'h05)
module tb_c_reg_fd_v5_0;
  logic       clk;
  logic       rst_n;
  logic [7:0] d;
  logic       ce, sclr, sset, sinit;

  int vectors = 0;
  int miscompares = 0;

  c_reg_fd_v5_0_if #(.C_WIDTH(8)) bus0 ();
  c_reg_fd_v5_0_if #(.C_WIDTH(8)) bus1 ();
  c_reg_fd_v5_0_if #(.C_WIDTH(8)) bus2 ();

  assign bus0.D = d; assign bus0.CE = ce; assign bus0.SCLR = sclr;
  assign bus0.SSET = sset; assign bus0.SINIT = sinit;
  assign bus1.D = d; assign bus1.CE = ce; assign bus1.SCLR = sclr;
  assign bus1.SSET = sset; assign bus1.SINIT = sinit;
  assign bus2.D = d; assign bus2.CE = ce; assign bus2.SCLR = sclr;
  assign bus2.SSET = sset; assign bus2.SINIT = sinit;

  c_reg_fd_v5_0 #(
    .C_WIDTH(8), .C_AINIT_VAL("10100101"), .C_SINIT_VAL("00001111"),
    .C_HAS_CE(1), .C_HAS_SCLR(1), .C_HAS_SSET(1), .C_HAS_SINIT(1),
    .C_SYNC_ENABLE(0), .C_SYNC_PRIORITY(1), .C_ENABLE_RLOCS(1)
  ) u0 (.CLK(clk), .ACLR_N(rst_n), .bus(bus0));

  c_reg_fd_v5_0 #(
    .C_WIDTH(8), .C_AINIT_VAL("10100101"), .C_SINIT_VAL("00001111"),
    .C_HAS_CE(1), .C_HAS_SCLR(1), .C_HAS_SSET(1), .C_HAS_SINIT(1),
    .C_SYNC_ENABLE(1), .C_SYNC_PRIORITY(0), .C_ENABLE_RLOCS(0)
  ) u1 (.CLK(clk), .ACLR_N(rst_n), .bus(bus1));

  c_reg_fd_v5_0 #(
    .C_WIDTH(8), .C_AINIT_VAL("101"), .C_SINIT_VAL("11111111"),
    .C_HAS_CE(0), .C_HAS_SCLR(0), .C_HAS_SSET(0), .C_HAS_SINIT(0),
    .C_SYNC_ENABLE(0), .C_SYNC_PRIORITY(1), .C_ENABLE_RLOCS(1)
  ) u2 (.CLK(clk), .ACLR_N(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk3(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                      input logic [7:0] e2);
    chk({tag, "/u0"}, bus0.Q, e0);
    chk({tag, "/u1"}, bus1.Q, e1);
    chk({tag, "/u2"}, bus2.Q, e2);
  endtask

  task automatic drive(input logic [7:0] dv, input logic cev, input logic sclrv,
                       input logic ssetv, input logic sinitv);
    d = dv; ce = cev; sclr = sclrv; sset = ssetv; sinit = sinitv;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk3("reset", 8'hA5, 8'hA5, 8'h05);

    rst_n = 1'b1;
    drive(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk3("load_3c", 8'h3C, 8'h3C, 8'h3C);

    drive(8'h55, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk3("ce0_edge1", 8'h3C, 8'h3C, 8'h55);
    tick();
    chk3("ce0_edge2", 8'h3C, 8'h3C, 8'h55);
    ce = 1'b1; tick();
    chk3("ce1_load55", 8'h55, 8'h55, 8'h55);

    drive(8'h0F, 1'b1, 1'b1, 1'b1, 1'b0); tick();
    chk3("sclr_sset", 8'h00, 8'hFF, 8'h0F);

    drive(8'hAA, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    chk3("sinit_sset", 8'h0F, 8'h0F, 8'hAA);

    drive(8'h77, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk3("load_77", 8'h77, 8'h77, 8'h77);

    drive(8'h11, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    chk3("sclr_ce0", 8'h00, 8'h77, 8'h11);

    drive(8'h22, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    chk3("sset_ce0", 8'hFF, 8'h77, 8'h22);

    drive(8'h33, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    chk3("sinit_ce0", 8'h0F, 8'h77, 8'h33);

    drive(8'h44, 1'b1, 1'b0, 1'b1, 1'b0); tick();
    chk3("sset_ce1", 8'hFF, 8'hFF, 8'h44);

    drive(8'h66, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    chk3("sclr_ce1", 8'h00, 8'h00, 8'h66);

    drive(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk3("load_5a", 8'h5A, 8'h5A, 8'h5A);

    // Q must not follow D between edges
    d = 8'hC3; #2;
    chk3("no_comb_path", 8'h5A, 8'h5A, 8'h5A);

    // async clear mid-cycle, no clock edge in between
    rst_n = 1'b0; #1;
    chk3("aclr_immediate", 8'hA5, 8'hA5, 8'h05);
    drive(8'h99, 1'b1, 1'b0, 1'b1, 1'b0); tick();
    chk3("aclr_held", 8'hA5, 8'hA5, 8'h05);

    rst_n = 1'b1;
    drive(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk3("after_release", 8'h3C, 8'h3C, 8'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
